// File: rtl/vga_line_fetch.sv
// rtl/vga_line_fetch.sv - ping-pong line prefetch and pixel output stage behind the VGA timing controller
module vga_line_fetch #(
  parameter int HVID    = 640,
  parameter int VVID    = 480,
  parameter int VTOTAL  = 521,
  parameter int DATA_W  = 12,
  parameter int ADDR_W  = 19,
  parameter int FB_BASE = 0
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              pix_en,
  input  logic [9:0]        x_coord,
  input  logic [9:0]        y_coord,
  input  logic              video_on_in,
  input  logic              hsync_in,
  input  logic              vsync_in,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] rgb,
  output logic              video_on,
  output logic              hsync,
  output logic              vsync,
  output logic              underflow
);

  localparam int COL_W = (HVID > 1) ? $clog2(HVID) : 1;

  typedef enum logic {IDLE, FETCH} state_t;

  state_t            state;
  logic              bank;
  logic [COL_W-1:0]  col;
  logic [1:0]        ready;
  logic [DATA_W-1:0] line_mem [2][HVID];

  logic              trigger;
  logic [9:0]        next_line;
  logic              fetch_needed;
  logic [ADDR_W-1:0] start_addr;
  logic [COL_W-1:0]  rd_col;
  logic              rd_bank;

  // Once-per-line trigger and the address of the line that must be ready by the next line
  always_comb begin
    trigger      = pix_en && (x_coord == 10'd0);
    next_line    = (y_coord == 10'(VTOTAL - 1)) ? 10'd0 : y_coord + 10'd1;
    fetch_needed = 32'(next_line) < VVID;
    start_addr   = ADDR_W'(FB_BASE) + ADDR_W'(next_line) * ADDR_W'(HVID);
    rd_bank      = y_coord[0];
    rd_col       = (32'(x_coord) < HVID) ? COL_W'(x_coord) : '0;
  end

  // Fetch FSM: a new trigger always wins, abandoning any unfinished fetch
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state    <= IDLE;
      bank     <= 1'b0;
      col      <= '0;
      ready    <= 2'b00;
      mem_req  <= 1'b0;
      mem_addr <= '0;
    end else if (trigger) begin
      if (fetch_needed) begin
        state               <= FETCH;
        bank                <= next_line[0];
        col                 <= '0;
        ready[next_line[0]] <= 1'b0;
        mem_req             <= 1'b1;
        mem_addr            <= start_addr;
      end else begin
        state   <= IDLE;
        mem_req <= 1'b0;
      end
    end else if (state == FETCH && mem_ack) begin
      if (col == COL_W'(HVID - 1)) begin
        ready[bank] <= 1'b1;
        state       <= IDLE;
        mem_req     <= 1'b0;
      end else begin
        col      <= col + COL_W'(1);
        mem_addr <= mem_addr + ADDR_W'(1);
      end
    end
  end

  // Line buffer write port: each accepted word lands at its column in the fetch bank
  always_ff @(posedge clk) begin
    if (state == FETCH && mem_ack) begin
      line_mem[bank][col] <= mem_rdata;
    end
  end

  // Output pipeline: one pix_en of latency, blank pixels from a bank that is not ready
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rgb      <= '0;
      video_on <= 1'b0;
      hsync    <= 1'b0;
      vsync    <= 1'b0;
    end else if (pix_en) begin
      video_on <= video_on_in;
      hsync    <= hsync_in;
      vsync    <= vsync_in;
      if (video_on_in && ready[rd_bank]) begin
        rgb <= line_mem[rd_bank][rd_col];
      end else begin
        rgb <= '0;
      end
    end
  end

  // Sticky error: a fetch overrun by the next trigger, or an active pixel from an unready bank
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      underflow <= 1'b0;
    end else if ((trigger && state == FETCH) ||
                 (pix_en && video_on_in && !ready[rd_bank])) begin
      underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vga_line_fetch.sv
// tb/tb_vga_line_fetch.sv - directed scoreboard bench for vga_line_fetch
module tb_vga_line_fetch;

  localparam int HVID    = 16;
  localparam int VVID    = 6;
  localparam int VTOTAL  = 9;
  localparam int HTOTAL  = 24;
  localparam int DATA_W  = 12;
  localparam int ADDR_W  = 19;
  localparam int FB_BASE = (1 << ADDR_W) - 3 * HVID - 8;

  typedef struct packed {
    logic [DATA_W-1:0] rgb;
    logic              von;
    logic              hs;
    logic              vs;
  } exp_t;

  logic              clk = 1'b0;
  logic              n_rst;
  logic              pix_en;
  logic [9:0]        x_coord;
  logic [9:0]        y_coord;
  logic              video_on_in;
  logic              hsync_in;
  logic              vsync_in;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack = 1'b0;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] rgb;
  logic              video_on;
  logic              hsync;
  logic              vsync;
  logic              underflow;

  int   tests = 0;
  int   fails = 0;
  int   ack_mode = 0;
  logic tog = 1'b0;
  int   req_cnt = 0;
  int   req_snap;
  exp_t sb[$];

  vga_line_fetch #(
    .HVID(HVID), .VVID(VVID), .VTOTAL(VTOTAL),
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .FB_BASE(FB_BASE)
  ) dut (
    .clk(clk), .n_rst(n_rst), .pix_en(pix_en),
    .x_coord(x_coord), .y_coord(y_coord),
    .video_on_in(video_on_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .rgb(rgb), .video_on(video_on), .hsync(hsync), .vsync(vsync), .underflow(underflow)
  );

  always #5 clk = ~clk;

  // memory model: word content is the low address bits; ack pattern chosen by ack_mode
  assign mem_rdata = mem_addr[DATA_W-1:0];

  always @(negedge clk) begin
    tog = ~tog;
    mem_ack = (ack_mode == 1) || (ack_mode == 2 && tog);
  end

  always @(posedge clk) begin
    if (mem_req) req_cnt <= req_cnt + 1;
  end

  function automatic logic [ADDR_W-1:0] exp_addr(int line, int col);
    logic [31:0] a;
    a = FB_BASE + line * HVID + col;
    return a[ADDR_W-1:0];
  endfunction

  function automatic logic [DATA_W-1:0] exp_pix(int line, int col);
    logic [ADDR_W-1:0] a;
    a = exp_addr(line, col);
    return a[DATA_W-1:0];
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    n_rst = 1'b0;
    idle(2);
    n_rst = 1'b1;
    idle(1);
  endtask

  task automatic pix(int x, int y, logic von, logic hs, logic vs, logic [DATA_W-1:0] erg);
    exp_t e;
    x_coord     = 10'(x);
    y_coord     = 10'(y);
    video_on_in = von;
    hsync_in    = hs;
    vsync_in    = vs;
    pix_en      = 1'b1;
    sb.push_back('{erg, von, hs, vs});
    @(posedge clk);
    #1;
    pix_en = 1'b0;
    e = sb.pop_front();
    check($sformatf("rgb y%0d x%0d", y, x), 32'(rgb), 32'(e.rgb));
    check($sformatf("video_on y%0d x%0d", y, x), 32'(video_on), 32'(e.von));
    check($sformatf("hsync y%0d x%0d", y, x), 32'(hsync), 32'(e.hs));
    check($sformatf("vsync y%0d x%0d", y, x), 32'(vsync), 32'(e.vs));
  endtask

  task automatic run_line(int y, int x0, int gap, bit bad);
    logic von;
    for (int x = x0; x < HTOTAL; x++) begin
      von = (x < HVID) && (y < VVID);
      pix(x, y, von, (x >= 18 && x <= 20), (y == 7),
          (von && !bad) ? exp_pix(y, x) : '0);
      idle(gap);
    end
  endtask

  task automatic run_frame(int gap);
    for (int y = 0; y < VTOTAL; y++) run_line(y, 0, gap, 1'b0);
  endtask

  initial begin
    n_rst = 1'b0;
    pix_en = 1'b0;
    x_coord = '0;
    y_coord = '0;
    video_on_in = 1'b0;
    hsync_in = 1'b0;
    vsync_in = 1'b0;

    // reset state
    idle(2);
    check("rst rgb", 32'(rgb), 0);
    check("rst video_on", 32'(video_on), 0);
    check("rst hsync", 32'(hsync), 0);
    check("rst vsync", 32'(vsync), 0);
    check("rst mem_req", 32'(mem_req), 0);
    check("rst mem_addr", 32'(mem_addr), 0);
    check("rst underflow", 32'(underflow), 0);
    n_rst = 1'b1;
    idle(1);

    // reset in the middle of a fetch
    ack_mode = 1;
    idle(1);
    pix(0, VTOTAL - 1, 1'b0, 1'b0, 1'b0, '0);
    idle(10);
    check("mid mem_req", 32'(mem_req), 1);
    check("mid mem_addr", 32'(mem_addr), 32'(exp_addr(0, 10)));
    n_rst = 1'b0;
    #1;
    check("abort mem_req", 32'(mem_req), 0);
    check("abort mem_addr", 32'(mem_addr), 0);
    check("abort rgb", 32'(rgb), 0);
    check("abort underflow", 32'(underflow), 0);
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    idle(4);
    check("post-abort idle mem_req", 32'(mem_req), 0);
    pix(3, 0, 1'b1, 1'b0, 1'b0, '0);
    check("bank0 not ready underflow", 32'(underflow), 1);
    pix(3, 1, 1'b1, 1'b0, 1'b0, '0);

    // single fetch with ack tied high; line 3 crosses the address wrap
    do_reset();
    pix(0, 2, 1'b0, 1'b0, 1'b0, '0);
    for (int k = 0; k < HVID; k++) begin
      check($sformatf("fetch req k%0d", k), 32'(mem_req), 1);
      check($sformatf("fetch addr k%0d", k), 32'(mem_addr), 32'(exp_addr(3, k)));
      idle(1);
    end
    check("fetch done mem_req", 32'(mem_req), 0);
    pix(5, 3, 1'b1, 1'b0, 1'b0, exp_pix(3, 5));
    pix(HVID - 1, 3, 1'b1, 1'b0, 1'b0, exp_pix(3, HVID - 1));
    check("fetch underflow", 32'(underflow), 0);

    // full frame, fast memory, pix_en every clock
    do_reset();
    run_line(VTOTAL - 1, 0, 0, 1'b0);
    run_frame(0);
    check("frame underflow", 32'(underflow), 0);

    // slow memory: ack every 2nd clock, pix_en every 4th clock, two frames
    ack_mode = 2;
    run_frame(3);
    run_frame(3);
    check("slow underflow", 32'(underflow), 0);

    // starved memory for a whole line
    do_reset();
    ack_mode = 1;
    run_line(VTOTAL - 1, 0, 0, 1'b0);
    ack_mode = 0;
    run_line(0, 0, 0, 1'b0);
    check("starve before trigger underflow", 32'(underflow), 0);
    pix(0, 1, 1'b1, 1'b0, 1'b0, '0);
    check("starve underflow", 32'(underflow), 1);
    check("restart mem_req", 32'(mem_req), 1);
    check("restart mem_addr", 32'(mem_addr), 32'(exp_addr(2, 0)));
    ack_mode = 1;
    run_line(1, 1, 0, 1'b1);
    run_line(2, 0, 0, 1'b0);
    run_line(3, 0, 0, 1'b0);
    run_line(4, 0, 0, 1'b0);

    // blanking lines issue no requests; last line fetches line 0 at FB_BASE
    req_snap = req_cnt;
    run_line(5, 0, 0, 1'b0);
    run_line(6, 0, 0, 1'b0);
    run_line(7, 0, 0, 1'b0);
    check("blank no requests", 32'(req_cnt - req_snap), 0);
    pix(0, VTOTAL - 1, 1'b0, 1'b0, 1'b0, '0);
    check("line0 mem_req", 32'(mem_req), 1);
    check("line0 mem_addr", 32'(mem_addr), 32'(FB_BASE));
    idle(HVID + 2);
    check("line0 done mem_req", 32'(mem_req), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
